// File: rtl/cute_arb_pkg.sv
// Shared types and constants for the mux select arbiter.
package cute_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam logic [3:0] SEL_IDLE      = 4'hF;
    localparam int         ARB_N_REQ_MAX = 10;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping, optionally skipping one index.
module rr_pick #(
    parameter int N_REQ = 10,
    parameter int SEL_W = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [SEL_W-1:0] excl_idx,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [SEL_W:0]   sum;
            logic [SEL_W-1:0] c;
            sum = {1'b0, ptr} + (SEL_W+1)'(i);
            if (sum >= (SEL_W+1)'(N_REQ))
                sum = sum - (SEL_W+1)'(N_REQ);
            c = sum[SEL_W-1:0];
            if (!found && req[c] && !(excl_en && c == excl_idx)) begin
                found = 1'b1;
                idx   = c;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the 10:1 mux select; idle code 4'hF when nobody holds it.
// Optional hold-time limit with forced handover: define ARB_HOLD_LIMIT_EN.
module mux_sel_arbiter
    import cute_arb_pkg::*;
#(
    parameter int N_REQ    = 10,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             preempt
);

    arb_state_t       state, state_nxt;
    logic [SEL_W-1:0] ptr;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             owner_req;
    logic             take, go_idle, pre_nxt;

    // gnt is one-hot, so this is req[owner] without indexing by the idle code
    assign owner_req = |(req & gnt);

    rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
        .req      (req),
        .ptr      (ptr),
        .excl_en  (state == ARB_GRANT),
        .excl_idx (sel),
        .found    (pick_found),
        .idx      (pick_idx)
    );

`ifdef ARB_HOLD_LIMIT_EN
    localparam int              HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (take)
            hold_cnt <= '0;
        else if (state == ARB_GRANT && hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + HOLD_W'(1);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^MAX_HOLD;
`endif

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        go_idle   = 1'b0;
        pre_nxt   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    take      = 1'b1;
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        go_idle   = 1'b1;
                        state_nxt = ARB_IDLE;
                    end
                end
`ifdef ARB_HOLD_LIMIT_EN
                // ptr already points past the owner, so the picker yields the next requester after k
                else if (hold_cnt == HOLD_LAST && pick_found) begin
                    take    = 1'b1;
                    pre_nxt = 1'b1;
                end
`endif
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            sel       <= SEL_W'(SEL_IDLE);
            sel_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state   <= state_nxt;
            preempt <= pre_nxt;
            if (take) begin
                gnt       <= N_REQ'(1) << pick_idx;
                sel       <= pick_idx;
                sel_valid <= 1'b1;
                ptr       <= (pick_idx == SEL_W'(N_REQ - 1)) ? '0 : pick_idx + SEL_W'(1);
            end else if (go_idle) begin
                gnt       <= '0;
                sel       <= SEL_W'(SEL_IDLE);
                sel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter (default build, no hold limit).
module tb_mux_sel_arbiter;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [3:0]   sel;
    logic         sel_valid;
    logic         preempt;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [3:0]   sel;
        logic         vld;
        logic         pre;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   seen[N];

    mux_sel_arbiter #(.N_REQ(N), .SEL_W(4), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] r, input int p, input int excl);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (p + i) % N;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    // Advance the reference model by one sampled edge and queue what the DUT should show after it.
    task automatic model_push(input logic [N-1:0] r);
        int   nxt;
        exp_t e;
        if (m_owner < 0)        nxt = rr_next(r, m_ptr, -1);
        else if (!r[m_owner])   nxt = rr_next(r, m_ptr, m_owner);
        else                    nxt = m_owner;
        if (nxt >= 0 && nxt != m_owner) m_ptr = (nxt + 1) % N;
        m_owner = nxt;
        e.pre = 1'b0;
        if (nxt < 0) begin
            e.gnt = '0; e.sel = 4'hF; e.vld = 1'b0;
        end else begin
            e.gnt = N'(1) << nxt; e.sel = 4'(nxt); e.vld = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input string tag, input logic [N-1:0] r);
        exp_t e;
        req = r;
        model_push(r);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
        chk({tag, "_sel"}, 32'(sel), 32'(e.sel));
        chk({tag, "_vld"}, 32'(sel_valid), 32'(e.vld));
        chk({tag, "_pre"}, 32'(preempt), 32'(e.pre));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        #12;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_sel", 32'(sel), 32'hF);
        chk("rst_vld", 32'(sel_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) step("idle", '0);

        step("t2a", 10'b00_0001_0100);
        chk("t2a_sel2", 32'(sel), 2);
        step("t2b", 10'b00_0001_0000);
        chk("t2b_sel4", 32'(sel), 4);
        step("t2c", '0);

        step("t3a", 10'b10_0000_0000);
        chk("t3a_sel9", 32'(sel), 9);
        step("t3b", 10'b01_0000_0001);
        chk("t3b_wrap0", 32'(sel), 0);
        step("t3c", 10'b01_0000_0010);
        chk("t3c_ptr1", 32'(sel), 1);
        step("t3d", '0);
        step("t3e", '0);

        // Every requester asks; the current owner releases right after its grant cycle.
        step("t4_0", {N{1'b1}});
        for (int k = 0; k < N; k++) seen[k] = 0;
        for (int g = 0; g < N; g++) begin
            seen[sel]++;
            step("t4", ~gnt);
        end
        for (int k = 0; k < N; k++) chk("t4_fair", 32'(seen[k]), 1);
        step("t4_end", '0);
        step("t4_end2", '0);

        step("t6a", 10'b00_1000_0000);
        chk("t6a_sel7", 32'(sel), 7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_gnt", 32'(gnt), 0);
        chk("t6_async_sel", 32'(sel), 32'hF);
        chk("t6_async_vld", 32'(sel_valid), 0);
        m_owner = -1;
        m_ptr   = 0;
        req     = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("t6b", 10'b01_0000_1000);
        chk("t6b_from0", 32'(sel), 3);

        for (int i = 0; i < 8; i++) begin
            step("t5", 10'b00_0010_1000);
            chk("t5_hold3", 32'(sel), 3);
        end
        step("t5_rel", 10'b00_0010_0000);
        chk("t5_sel5", 32'(sel), 5);
        step("t5_end", '0);

        for (int i = 0; i < 30; i++) step("rnd", N'($urandom_range(0, 1023)));

        chk("q_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
